sync_channel_arb: RTL and testbench

SYNC_CHANNEL_ARB -- requirements
Module: sync_channel_arb

---
 rtl/sync_arb_pkg.sv | 17 +
 rtl/sync_rr_pick.sv | 31 +++
 rtl/sync_channel_arb.sv | 138 +++++++++++++
 tb/tb_sync_channel_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_arb_pkg.sv
// Shared definitions for the synchroniser channel arbiter: FSM encodings and
// the default ack timeout.
package sync_arb_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_DRIVE_ENC = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    DRIVE = ST_DRIVE_ENC,
    DRAIN = ST_DRAIN_ENC
  } arb_state_t;

endpackage

// File: rtl/sync_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping around, reported both one-hot and as an index.
module sync_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic [PW-1:0]   winner_idx,
  output logic            found
);

  logic [PW-1:0] pos;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    pos        = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = PW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[pos]) begin
        found       = 1'b1;
        winner[pos] = 1'b1;
        winner_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/sync_channel_arb.sv
// Round-robin arbiter sharing one req/ack synchroniser between NREQ requesters,
// with a per-phase ack timeout.
//   state | meaning
//   IDLE  | arbitrate pending requests, launch winner's word
//   DRIVE | sync_dready high, waiting for sync_ack to rise
//   DRAIN | sync_dready low, waiting for sync_ack to fall
module sync_channel_arb
  import sync_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DWIDTH-1:0]      sync_din,
  output logic                   sync_dready,
  input  logic                   sync_ack,
  output logic                   busy,
  output logic                   err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

  arb_state_t        state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     cur_idx;
  logic [PW-1:0]     next_ptr;
  logic [NREQ-1:0]   cur_onehot;
  logic              timed_out;

  logic [NREQ-1:0]   pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_found;
  logic [DWIDTH-1:0] pick_data;

  sync_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  assign pick_data = req_data[int'(pick_idx)*DWIDTH +: DWIDTH];
  assign next_ptr  = (cur_idx == IDX_LAST) ? '0 : cur_idx + 1'b1;
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      cur_onehot  <= '0;
      timed_out   <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      sync_din    <= '0;
      sync_dready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_found) begin
            state       <= DRIVE;
            busy        <= 1'b1;
            gnt         <= pick_onehot;
            cur_onehot  <= pick_onehot;
            cur_idx     <= pick_idx;
            sync_din    <= pick_data;
            sync_dready <= 1'b1;
            timed_out   <= 1'b0;
          end
        end
        DRIVE: begin
          if (sync_ack) begin
            state       <= DRAIN;
            sync_dready <= 1'b0;
            cnt         <= '0;
          end else if (cnt == CNT_LAST) begin
            // A transfer that timed out here never reports done, even if
            // the ack then settles low normally.
            state       <= DRAIN;
            sync_dready <= 1'b0;
            cnt         <= '0;
            err         <= 1'b1;
            timed_out   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DRAIN: begin
          if (!sync_ack) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            rr_ptr <= next_ptr;
            if (!timed_out) done <= cur_onehot;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            err    <= 1'b1;
            rr_ptr <= next_ptr;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          sync_dready <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_channel_arb.sv
// Scoreboard bench for sync_channel_arb: stimulus pushes expected transfers,
// a negedge monitor pops and checks them as grants and completions appear.
module tb_sync_channel_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   sync_din;
  logic            sync_dready;
  logic            sync_ack = 1'b0;
  logic            busy;
  logic            err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    bit            exp_done;
    int            exp_err;
    int            dlen;
    int            blen;
  } xfer_t;

  xfer_t      sbq[$];
  int         ack_mode = 0;   // 0 normal, 1 never acks, 2 ack stuck high
  logic [3:0] hist = '0;
  int         mptr = 0;

  always #5 clk = ~clk;

  sync_channel_arb #(
    .NREQ    (N),
    .DWIDTH  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .sync_din    (sync_din),
    .sync_dready (sync_dready),
    .sync_ack    (sync_ack),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Synchroniser model: ack follows sync_dready four cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      hist = {hist[2:0], sync_dready};
      case (ack_mode)
        0:       sync_ack = hist[3];
        1:       sync_ack = 1'b0;
        default: sync_ack = sync_ack | hist[3];
      endcase
    end
  end

  // Monitor
  xfer_t        cur;
  bit           in_xfer = 0;
  bit           prev_busy = 0;
  bit           saw_done = 0;
  logic [N-1:0] done_val = '0;
  int           err_cnt = 0;
  int           dr_len = 0;
  int           bs_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_xfer   = 0;
      prev_busy = 0;
    end else begin
      if (gnt != '0) begin
        chk("gnt_onehot", $countones(gnt), 1);
        chk("gnt_while_busy", prev_busy, 0);
        if (sbq.size() == 0) begin
          chk("gnt_unexpected", gnt, 0);
        end else begin
          cur = sbq.pop_front();
          chk("gnt_winner", gnt, 1 << cur.idx);
          chk("din_at_gnt", sync_din, cur.data);
          in_xfer  = 1;
          saw_done = 0;
          err_cnt  = 0;
          dr_len   = 0;
          bs_len   = 0;
        end
      end
      if (in_xfer) begin
        if (busy) begin
          bs_len++;
          chk("din_stable", sync_din, cur.data);
        end
        if (sync_dready) dr_len++;
        if (done != '0) begin
          saw_done = 1;
          done_val = done;
        end
        if (err) err_cnt++;
        if (!busy) begin
          chk("done_seen", saw_done, cur.exp_done);
          if (cur.exp_done) chk("done_vector", done_val, 1 << cur.idx);
          chk("err_count", err_cnt, cur.exp_err);
          chk("dready_cycles", dr_len, cur.dlen);
          chk("busy_cycles", bs_len, cur.blen);
          in_xfer = 0;
        end
      end else begin
        if (done != '0) chk("done_unexpected", done, 0);
        if (err) chk("err_unexpected", err, 0);
      end
      prev_busy = busy;
    end
  end

  // Reference model helpers
  function automatic int pick(input logic [N-1:0] r, input int p);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic xfer_t make_rec(input int w, input logic [DW-1:0] d, input int mode);
    xfer_t x;
    x.idx  = w;
    x.data = d;
    case (mode)
      1: begin x.exp_done = 0; x.exp_err = 1; x.dlen = TO; x.blen = TO + 1; end
      2: begin x.exp_done = 0; x.exp_err = 1; x.dlen = 4;  x.blen = 4 + TO; end
      default: begin x.exp_done = 1; x.exp_err = 0; x.dlen = 4; x.blen = 8; end
    endcase
    return x;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      wait_cycles(1);
      if (gnt != '0) ok = 1;
    end
    chk("gnt_seen", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      wait_cycles(1);
      if (!busy) ok = 1;
    end
    chk("idle_seen", ok, 1);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic do_xfer(input logic [N-1:0] pat, input int mode, input int fdata);
    int w;
    logic [DW-1:0] d;
    randomize_data();
    w = pick(pat, mptr);
    if (fdata >= 0) req_data[w*DW +: DW] = DW'(fdata);
    d = req_data[w*DW +: DW];
    sbq.push_back(make_rec(w, d, mode));
    ack_mode = mode;
    req = pat;
    wait_gnt();
    req = '0;
    randomize_data();
    wait_idle();
    mptr = (w + 1) % N;
    ack_mode = 0;
    wait_cycles(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ngnt;
    logic [N-1:0] pat;
    int mode;

    rst = 1'b1;
    wait_cycles(2);
    chk("reset_gnt", gnt, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_dready", sync_dready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_din", sync_din, 0);
    rst = 1'b0;

    wait_cycles(4);
    chk("idle_busy", busy, 0);
    chk("idle_dready", sync_dready, 0);
    chk("idle_gnt", gnt, 0);

    // All requesters held: rotation starting from requester 0.
    randomize_data();
    for (int k = 0; k < 5; k++) begin
      w = pick(4'hF, mptr);
      sbq.push_back(make_rec(w, req_data[w*DW +: DW], 0));
      mptr = (w + 1) % N;
    end
    ack_mode = 0;
    req = 4'hF;
    ngnt = 0;
    for (int i = 0; i < 120 && ngnt < 5; i++) begin
      wait_cycles(1);
      if (gnt != '0) ngnt++;
    end
    chk("held_grants", ngnt, 5);
    req = '0;
    wait_idle();
    wait_cycles(2);

    do_xfer(4'b0010, 0, 8'hA5);
    do_xfer(4'b0001, 1, -1);
    do_xfer(4'b1000, 2, -1);
    do_xfer(4'b0100, 0, -1);

    // Reset two cycles into DRIVE abandons the transfer silently.
    randomize_data();
    w = pick(4'b0100, mptr);
    sbq.push_back(make_rec(w, req_data[w*DW +: DW], 0));
    req = 4'b0100;
    wait_gnt();
    req = '0;
    wait_cycles(1);
    rst = 1'b1;
    wait_cycles(1);
    chk("midreset_gnt", gnt, 0);
    chk("midreset_done", done, 0);
    chk("midreset_err", err, 0);
    chk("midreset_dready", sync_dready, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_din", sync_din, 0);
    rst = 1'b0;
    mptr = 0;
    wait_cycles(10);
    do_xfer(4'b1111, 0, -1);

    for (int t = 0; t < 14; t++) begin
      pat  = N'($urandom_range(1, 15));
      mode = $urandom_range(0, 5);
      if (mode < 4) mode = 0;
      else if (mode == 4) mode = 1;
      else mode = 2;
      do_xfer(pat, mode, -1);
    end

    wait_cycles(5);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("xfer_closed", in_xfer, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
